ac_motor_deadtime: RTL and testbench

Per-leg dead-time and protection stage directly downstream of the AC motor PWM comparator. It takes the raw high-side/low-side commands and the leg enable produced by the comparator and converts them into registered gate drives for one half-bridge leg. It guarantees that the two gates are never on together, with a programmable minimum off gap before any turn-on. It also latches an external fault or a command overlap into a safe all-off state. One instance is used per phase leg.

---
 rtl/ac_motor_pkg.sv | 31 +++
 rtl/ac_motor_sync.sv | 24 ++
 rtl/ac_motor_deadtime.sv | 104 ++++++++++
 tb/tb_ac_motor_deadtime.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_motor_pkg.sv
// Shared types and constants for the AC motor gate-drive path.
// Leg state encoding, default dead time and the command-to-desired-state decode.
package ac_motor_pkg;

    typedef enum logic [1:0] {
        LEG_OFF   = 2'd0,
        LEG_HI    = 2'd1,
        LEG_LO    = 2'd2,
        LEG_FAULT = 2'd3
    } leg_state_t;

    // 1 us at 50 MHz; the motor top level ties each leg's dead_time to this
    localparam logic [7:0] AC_MOTOR_DT_DEFAULT = 8'd50;

    // Simultaneous hi/lo commands resolve to OFF, never to either side
    function automatic leg_state_t desired_state(
        input logic en,
        input logic hi,
        input logic lo
    );
        leg_state_t d;
        d = LEG_OFF;
        if (en && hi && !lo) begin
            d = LEG_HI;
        end else if (en && lo && !hi) begin
            d = LEG_LO;
        end
        return d;
    endfunction

endpackage

// File: rtl/ac_motor_sync.sv
// N-flop synchronizer for asynchronous motor-side inputs; output lags input by STAGES cycles.
// Asynchronously cleared to 0 so a fault never appears out of reset.
module ac_motor_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/ac_motor_deadtime.sv
// Per-leg dead-time insertion and fault latch between the PWM comparator and one half-bridge.
// Gates decode from the state register only, so they are glitch-free and never on together.
module ac_motor_deadtime
    import ac_motor_pkg::*;
#(
    parameter int DT_W        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            cmd_hi,
    input  logic            cmd_lo,
    input  logic [DT_W-1:0] dead_time,
    input  logic            fault_in,
    input  logic            fault_clr,
    output logic            gate_hi,
    output logic            gate_lo,
    output logic            fault,
    output logic            overlap_err
);

    leg_state_t      state;
    leg_state_t      state_next;
    leg_state_t      desired;
    logic [DT_W-1:0] off_cnt;
    logic            fault_sync;
    logic            gap_done;

    ac_motor_sync #(
        .STAGES (SYNC_STAGES)
    ) u_fault_sync (
        .clk   (clk),
        .reset (reset),
        .din   (fault_in),
        .dout  (fault_sync)
    );

    assign desired  = desired_state(enable, cmd_hi, cmd_lo);
    // dead_time is compared live so a mid-gap change takes effect immediately
    assign gap_done = (off_cnt >= dead_time);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LEG_OFF;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (fault_sync) begin
            state_next = LEG_FAULT;
        end else begin
            unique case (state)
                LEG_OFF: begin
                    if (desired != LEG_OFF && gap_done) begin
                        state_next = desired;
                    end
                end
                LEG_HI, LEG_LO: begin
                    // Always pass through OFF so the gap counter runs before the opposite side
                    if (desired != state) begin
                        state_next = LEG_OFF;
                    end
                end
                LEG_FAULT: begin
                    if (fault_clr) begin
                        state_next = LEG_OFF;
                    end
                end
                default: state_next = LEG_OFF;
            endcase
        end
    end

    always_comb begin
        gate_hi = (state == LEG_HI);
        gate_lo = (state == LEG_LO);
        fault   = (state == LEG_FAULT);
    end

    // Held at zero outside OFF, so every entry to OFF starts counting from 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            off_cnt <= '0;
        end else if (state != LEG_OFF) begin
            off_cnt <= '0;
        end else if (off_cnt != {DT_W{1'b1}}) begin
            off_cnt <= off_cnt + DT_W'(1);
        end
    end

    // A new overlap in the clearing cycle is still reported
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overlap_err <= 1'b0;
        end else begin
            overlap_err <= (overlap_err & ~fault_clr) | (cmd_hi & cmd_lo);
        end
    end

endmodule

// File: tb/tb_ac_motor_deadtime.sv
// Bench for ac_motor_deadtime: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a timestamp-based behavioural model.
module tb_ac_motor_deadtime;
    import ac_motor_pkg::*;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       cmd_hi = 1'b0;
    logic       cmd_lo = 1'b0;
    logic [7:0] dead_time = 8'd4;
    logic       fault_in = 1'b0;
    logic       fault_clr = 1'b0;
    logic       gate_hi;
    logic       gate_lo;
    logic       fault;
    logic       overlap_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mode 0=off 1=hi 2=lo 3=fault; off time derived from the edge index of OFF entry
    int m_mode = 0;
    int ec = 0;
    int off_since = 0;
    bit m_ovl = 1'b0;
    bit fin_q[$];

    always #10 clk = ~clk;

    ac_motor_deadtime #(
        .DT_W        (8),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cmd_hi      (cmd_hi),
        .cmd_lo      (cmd_lo),
        .dead_time   (dead_time),
        .fault_in    (fault_in),
        .fault_clr   (fault_clr),
        .gate_hi     (gate_hi),
        .gate_lo     (gate_lo),
        .fault       (fault),
        .overlap_err (overlap_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode    = 0;
        off_since = ec;
        m_ovl     = 1'b0;
        fin_q.delete();
    endtask

    task automatic model_edge();
        int cnt;
        int des;
        int nxt;
        bit fs;
        fs  = (fin_q.size() >= SYNC) ? fin_q[fin_q.size() - SYNC] : 1'b0;
        cnt = ec - off_since;
        if (cnt > 255) cnt = 255;
        if (!enable) des = 0;
        else if (cmd_hi && !cmd_lo) des = 1;
        else if (cmd_lo && !cmd_hi) des = 2;
        else des = 0;
        nxt = m_mode;
        if (fs) begin
            nxt = 3;
        end else if (m_mode == 3) begin
            if (fault_clr) nxt = 0;
        end else if (m_mode == 0) begin
            if (des != 0 && cnt >= int'(dead_time)) nxt = des;
        end else if (des != m_mode) begin
            nxt = 0;
        end
        if (nxt == 0 && m_mode != 0) off_since = ec + 1;
        m_ovl  = (m_ovl && !fault_clr) || (cmd_hi && cmd_lo);
        m_mode = nxt;
        fin_q.push_back(fault_in);
        ec++;
    endtask

    task automatic compare_all();
        chk("gate_hi", gate_hi, m_mode == 1);
        chk("gate_lo", gate_lo, m_mode == 2);
        chk("fault", fault, m_mode == 3);
        chk("overlap_err", overlap_err, m_ovl);
        chk("no_shoot_through", gate_hi & gate_lo, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Called at a negedge: asynchronous assert, one held edge, release at the next negedge
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        chk("reset_async_gate_hi", gate_hi, 0);
        chk("reset_async_gate_lo", gate_lo, 0);
        compare_all();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int r;
        model_reset();
        dead_time = 8'd4;
        enable    = 1'b1;
        cmd_hi    = 1'b1;
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Start-up: dead_time+1 OFF cycles before the first turn-on
        repeat (4) tick();
        chk("startup_pre", gate_hi, 0);
        tick();
        chk("startup_rise", gate_hi, 1);
        chk("startup_lo", gate_lo, 0);

        // Flip hi->lo: fall next cycle, rise 6 cycles after the flip with dead_time 4
        repeat (3) tick();
        cmd_hi = 1'b0; cmd_lo = 1'b1;
        tick();
        chk("flip_hi_fall", gate_hi, 0);
        repeat (4) tick();
        chk("flip_lo_pre", gate_lo, 0);
        tick();
        chk("flip_lo_rise", gate_lo, 1);

        // dead_time 0: exactly one empty cycle at every transition
        dead_time = 8'd0;
        for (int k = 0; k < 6; k++) begin
            cmd_hi = ~cmd_hi; cmd_lo = ~cmd_lo;
            tick();
            chk("dt0_gap", gate_hi | gate_lo, 0);
            tick();
            chk("dt0_on", cmd_hi ? gate_hi : gate_lo, 1);
            tick();
        end

        // Overlap while HI: gate drops, sticky error until fault_clr
        dead_time = 8'd4;
        cmd_hi = 1'b1; cmd_lo = 1'b0;
        repeat (6) tick();
        chk("pre_overlap_hi", gate_hi, 1);
        cmd_lo = 1'b1;
        tick();
        chk("overlap_drop", gate_hi, 0);
        chk("overlap_set", overlap_err, 1);
        cmd_lo = 1'b0;
        repeat (3) tick();
        chk("overlap_sticky", overlap_err, 1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("overlap_cleared", overlap_err, 0);

        // Fault pulse while LO, clear ignored while fault still present, then clean exit
        cmd_hi = 1'b0; cmd_lo = 1'b1;
        repeat (8) tick();
        chk("pre_fault_lo", gate_lo, 1);
        fault_in = 1'b1;
        tick();
        fault_in = 1'b0;
        repeat (2) tick();
        chk("fault_latency_gate", gate_lo, 0);
        chk("fault_latency_flag", fault, 1);
        fault_in = 1'b1;
        repeat (3) tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fault_clr_ignored", fault, 1);
        fault_in = 1'b0;
        repeat (3) tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fault_exit", fault, 0);
        repeat (4) tick();
        chk("post_fault_pre", gate_lo, 0);
        tick();
        chk("post_fault_rise", gate_lo, 1);

        // Reset mid-HI
        cmd_hi = 1'b1; cmd_lo = 1'b0;
        repeat (7) tick();
        chk("pre_reset_hi", gate_hi, 1);
        do_reset();
        repeat (4) tick();
        chk("post_reset_pre", gate_hi, 0);
        tick();
        chk("post_reset_rise", gate_hi, 1);

        // Counter saturation: long OFF with dead_time 255 permits immediate turn-on
        cmd_hi = 1'b0;
        dead_time = 8'd255;
        repeat (300) tick();
        cmd_hi = 1'b1;
        tick();
        chk("saturated_turn_on", gate_hi, 1);

        // Randomized traffic
        dead_time = 8'd3;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                r = int'($urandom_range(0, 99));
                if (r < 45) {cmd_hi, cmd_lo} = 2'b10;
                else if (r < 90) {cmd_hi, cmd_lo} = 2'b01;
                else if (r < 97) {cmd_hi, cmd_lo} = 2'b00;
                else {cmd_hi, cmd_lo} = 2'b11;
            end
            enable    = ($urandom_range(0, 49) != 0);
            fault_in  = ($urandom_range(0, 199) == 0);
            fault_clr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 299) == 0) dead_time = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 999) == 0) do_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
